// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/ready port driven by the MEM stage.
// master = MEM stage controller, slave = data memory.
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage: data-memory access, branch resolve, MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned word accesses.
module mem_stage_ctrl #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [4:0]        decoder_i,
  input  logic [DATA_W-1:0] br_target_i,
  input  logic              zero_i,
  input  logic [DATA_W-1:0] alu_rslt_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [REG_W-1:0]  wreg_i,
  output logic              stall_o,
  output logic              pc_src_o,
  output logic [DATA_W-1:0] br_target_o,
  mem_stage_ctrl_if.master  dmem,
  output logic              wb_valid_o,
  output logic              wb_regwrite_o,
  output logic              wb_memtoreg_o,
  output logic [DATA_W-1:0] wb_rdata_o,
  output logic [DATA_W-1:0] wb_alu_o,
  output logic [REG_W-1:0]  wb_wreg_o,
  output logic              bus_err_o
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mem_op, is_wr, misal;
  logic              acc, tmo;
  logic              wv_d, wrw_d, wm2r_d, err_d;
  logic [DATA_W-1:0] wrd_d, walu_d;
  logic [REG_W-1:0]  wreg_d;

  assign is_wr  = decoder_i[0];
  assign mem_op = valid_i & (decoder_i[1] | decoder_i[0]);

`ifdef MEM_ALIGN_CHECK_EN
  assign misal = mem_op & (alu_rslt_i[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  assign acc = (st_q == ACCESS);
  assign tmo = acc & (cnt_q >= CW'(TIMEOUT - 1));

  // reset must release the upstream hold immediately
  assign stall_o = ~rst_i & mem_op & ~misal
                 & ~(acc & (dmem.ready | tmo));

  assign pc_src_o    = valid_i & decoder_i[2]
                     & zero_i & ~stall_o;
  assign br_target_o = br_target_i;

  assign dmem.req   = acc;
  assign dmem.we    = acc & is_wr;
  assign dmem.addr  = acc ? alu_rslt_i : '0;
  assign dmem.wdata = acc ? store_data_i : '0;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    wv_d   = 1'b0;
    wrw_d  = 1'b0;
    wm2r_d = 1'b0;
    wrd_d  = '0;
    walu_d = '0;
    wreg_d = '0;
    err_d  = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (misal) begin
          err_d = 1'b1;
        end else if (mem_op) begin
          st_d  = ACCESS;
          cnt_d = '0;
        end else if (valid_i) begin
          wv_d   = 1'b1;
          wrw_d  = decoder_i[4];
          wm2r_d = decoder_i[3];
          walu_d = alu_rslt_i;
          wreg_d = wreg_i;
        end
      end
      ACCESS: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (dmem.ready) begin
          st_d   = IDLE;
          wv_d   = 1'b1;
          wrw_d  = decoder_i[4] & ~is_wr;
          wm2r_d = decoder_i[3];
          wrd_d  = is_wr ? '0 : dmem.rdata;
          walu_d = alu_rslt_i;
          wreg_d = wreg_i;
        end else if (tmo) begin
          st_d  = IDLE;
          err_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q          <= IDLE;
      cnt_q         <= '0;
      wb_valid_o    <= 1'b0;
      wb_regwrite_o <= 1'b0;
      wb_memtoreg_o <= 1'b0;
      wb_rdata_o    <= '0;
      wb_alu_o      <= '0;
      wb_wreg_o     <= '0;
      bus_err_o     <= 1'b0;
    end else begin
      st_q          <= st_d;
      cnt_q         <= cnt_d;
      wb_valid_o    <= wv_d;
      wb_regwrite_o <= wrw_d;
      wb_memtoreg_o <= wm2r_d;
      wb_rdata_o    <= wrd_d;
      wb_alu_o      <= walu_d;
      wb_wreg_o     <= wreg_d;
      bus_err_o     <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl.
// Define MEM_ALIGN_CHECK_EN to exercise the alignment check.
module tb_mem_stage_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [4:0]  decoder_i;
  logic [31:0] br_target_i;
  logic        zero_i;
  logic [31:0] alu_rslt_i;
  logic [31:0] store_data_i;
  logic [4:0]  wreg_i;
  logic        stall_o, pc_src_o;
  logic [31:0] br_target_o;
  logic        wb_valid_o, wb_regwrite_o, wb_memtoreg_o;
  logic [31:0] wb_rdata_o, wb_alu_o;
  logic [4:0]  wb_wreg_o;
  logic        bus_err_o;

  int errs = 0;
  int checks = 0;

  mem_stage_ctrl_if #(.DATA_W(32)) dmem ();

  mem_stage_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .decoder_i     (decoder_i),
    .br_target_i   (br_target_i),
    .zero_i        (zero_i),
    .alu_rslt_i    (alu_rslt_i),
    .store_data_i  (store_data_i),
    .wreg_i        (wreg_i),
    .stall_o       (stall_o),
    .pc_src_o      (pc_src_o),
    .br_target_o   (br_target_o),
    .dmem          (dmem.master),
    .wb_valid_o    (wb_valid_o),
    .wb_regwrite_o (wb_regwrite_o),
    .wb_memtoreg_o (wb_memtoreg_o),
    .wb_rdata_o    (wb_rdata_o),
    .wb_alu_o      (wb_alu_o),
    .wb_wreg_o     (wb_wreg_o),
    .bus_err_o     (bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i      = 1'b0;
    decoder_i    = 5'b0;
    alu_rslt_i   = 32'h0;
    store_data_i = 32'h0;
    wreg_i       = 5'd0;
    zero_i       = 1'b0;
    br_target_i  = 32'h0;
    dmem.ready   = 1'b0;
    dmem.rdata   = 32'h0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle_inputs();
    valid_i    = 1'b1;
    decoder_i  = 5'b11010;
    alu_rslt_i = 32'h100;
    tick();
    tick();
    checks++;
    if (stall_o !== 1'b0) begin
      errs++;
      $display("FAIL rst_stall: got %b want 0", stall_o);
    end
    checks++;
    if (dmem.req !== 1'b0) begin
      errs++;
      $display("FAIL rst_req: got %b want 0", dmem.req);
    end
    checks++;
    if ({wb_valid_o, wb_regwrite_o, bus_err_o} !== 3'b000) begin
      errs++;
      $display("FAIL rst_wb: got %b want 000",
               {wb_valid_o, wb_regwrite_o, bus_err_o});
    end
    idle_inputs();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_add();
    valid_i    = 1'b1;
    decoder_i  = 5'b10000;
    alu_rslt_i = 32'h0000_0011;
    wreg_i     = 5'd5;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errs++;
      $display("FAIL add_stall: got %b want 0", stall_o);
    end
    tick();
    idle_inputs();
    checks++;
    if ({wb_valid_o, wb_regwrite_o, wb_memtoreg_o} !== 3'b110) begin
      errs++;
      $display("FAIL add_ctl: got %b want 110",
               {wb_valid_o, wb_regwrite_o, wb_memtoreg_o});
    end
    checks++;
    if (wb_alu_o !== 32'h11 || wb_wreg_o !== 5'd5) begin
      errs++;
      $display("FAIL add_data: got %h/%0d want 11/5",
               wb_alu_o, wb_wreg_o);
    end
  endtask

  task automatic test_lw();
    int nstall;
    nstall = 0;
    valid_i    = 1'b1;
    decoder_i  = 5'b11010;
    alu_rslt_i = 32'h100;
    wreg_i     = 5'd7;
    #1;
    if (stall_o === 1'b1) nstall++;
    checks++;
    if (dmem.req !== 1'b0) begin
      errs++;
      $display("FAIL lw_idle_req: got %b want 0", dmem.req);
    end
    tick();
    if (stall_o === 1'b1) nstall++;
    checks++;
    if ({dmem.req, dmem.we} !== 2'b10 || dmem.addr !== 32'h100) begin
      errs++;
      $display("FAIL lw_req: got %b/%h want 10/100",
               {dmem.req, dmem.we}, dmem.addr);
    end
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errs++;
      $display("FAIL lw_bubble: got %b want 0", wb_valid_o);
    end
    tick();
    if (stall_o === 1'b1) nstall++;
    tick();
    dmem.ready = 1'b1;
    dmem.rdata = 32'hDEAD_BEEF;
    #1;
    if (stall_o === 1'b1) nstall++;
    checks++;
    if (nstall !== 3) begin
      errs++;
      $display("FAIL lw_stall_cycles: got %0d want 3", nstall);
    end
    tick();
    idle_inputs();
    checks++;
    if (wb_rdata_o !== 32'hDEAD_BEEF || wb_wreg_o !== 5'd7) begin
      errs++;
      $display("FAIL lw_rdata: got %h/%0d want deadbeef/7",
               wb_rdata_o, wb_wreg_o);
    end
    checks++;
    if ({wb_valid_o, wb_regwrite_o, wb_memtoreg_o} !== 3'b111) begin
      errs++;
      $display("FAIL lw_ctl: got %b want 111",
               {wb_valid_o, wb_regwrite_o, wb_memtoreg_o});
    end
  endtask

  task automatic test_back_to_back();
    valid_i      = 1'b1;
    decoder_i    = 5'b10001;
    alu_rslt_i   = 32'h104;
    store_data_i = 32'h5A;
    wreg_i       = 5'd9;
    dmem.ready   = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b1 || dmem.req !== 1'b0) begin
      errs++;
      $display("FAIL sw_idle: got stall=%b req=%b want 1/0",
               stall_o, dmem.req);
    end
    tick();
    checks++;
    if ({dmem.req, dmem.we, stall_o} !== 3'b110
        || dmem.addr !== 32'h104 || dmem.wdata !== 32'h5A) begin
      errs++;
      $display("FAIL sw_access: got %b %h %h want 110 104 5a",
               {dmem.req, dmem.we, stall_o}, dmem.addr, dmem.wdata);
    end
    tick();
    decoder_i  = 5'b11010;
    alu_rslt_i = 32'h108;
    wreg_i     = 5'd3;
    dmem.ready = 1'b0;
    #1;
    checks++;
    if ({wb_valid_o, wb_regwrite_o} !== 2'b10
        || wb_alu_o !== 32'h104) begin
      errs++;
      $display("FAIL sw_wb: got %b/%h want 10/104",
               {wb_valid_o, wb_regwrite_o}, wb_alu_o);
    end
    checks++;
    if (dmem.req !== 1'b0 || stall_o !== 1'b1) begin
      errs++;
      $display("FAIL b2b_gap: got req=%b stall=%b want 0/1",
               dmem.req, stall_o);
    end
    tick();
    checks++;
    if ({dmem.req, dmem.we} !== 2'b10 || dmem.addr !== 32'h108) begin
      errs++;
      $display("FAIL b2b_req: got %b/%h want 10/108",
               {dmem.req, dmem.we}, dmem.addr);
    end
    dmem.ready = 1'b1;
    dmem.rdata = 32'hCAFE_F00D;
    tick();
    idle_inputs();
    checks++;
    if (wb_rdata_o !== 32'hCAFE_F00D || wb_valid_o !== 1'b1) begin
      errs++;
      $display("FAIL b2b_rdata: got %h/%b want cafef00d/1",
               wb_rdata_o, wb_valid_o);
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    valid_i    = 1'b1;
    decoder_i  = 5'b11010;
    alu_rslt_i = 32'h200;
    wreg_i     = 5'd4;
    tick();
    for (int i = 0; i < 40; i++) begin
      if (dmem.req !== 1'b1) break;
      n++;
      if (n == 15) begin
        checks++;
        if (stall_o !== 1'b1) begin
          errs++;
          $display("FAIL to_stall15: got %b want 1", stall_o);
        end
      end
      if (n == 16) begin
        checks++;
        if (stall_o !== 1'b0) begin
          errs++;
          $display("FAIL to_stall16: got %b want 0", stall_o);
        end
      end
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (n !== 16) begin
      errs++;
      $display("FAIL to_req_cycles: got %0d want 16", n);
    end
    checks++;
    if ({bus_err_o, wb_valid_o, stall_o} !== 3'b100) begin
      errs++;
      $display("FAIL to_err: got %b want 100",
               {bus_err_o, wb_valid_o, stall_o});
    end
    tick();
    checks++;
    if (bus_err_o !== 1'b0) begin
      errs++;
      $display("FAIL to_pulse: got %b want 0", bus_err_o);
    end
  endtask

  task automatic test_beq();
    valid_i     = 1'b1;
    decoder_i   = 5'b00100;
    zero_i      = 1'b1;
    br_target_i = 32'h40;
    #1;
    checks++;
    if (pc_src_o !== 1'b1 || br_target_o !== 32'h40) begin
      errs++;
      $display("FAIL beq_taken: got %b/%h want 1/40",
               pc_src_o, br_target_o);
    end
    zero_i = 1'b0;
    #1;
    checks++;
    if (pc_src_o !== 1'b0) begin
      errs++;
      $display("FAIL beq_not_taken: got %b want 0", pc_src_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    valid_i    = 1'b1;
    decoder_i  = 5'b11010;
    alu_rslt_i = 32'h300;
    tick();
    checks++;
    if (dmem.req !== 1'b1) begin
      errs++;
      $display("FAIL rmid_pre: got %b want 1", dmem.req);
    end
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({dmem.req, stall_o, wb_valid_o, wb_regwrite_o} !== 4'b0000) begin
      errs++;
      $display("FAIL rmid: got %b want 0000",
               {dmem.req, stall_o, wb_valid_o, wb_regwrite_o});
    end
    idle_inputs();
    #1;
    rst_i = 1'b0;
    tick();
    checks++;
    if (dmem.req !== 1'b0) begin
      errs++;
      $display("FAIL rmid_noretry: got %b want 0", dmem.req);
    end
  endtask

  task automatic test_align();
    valid_i    = 1'b1;
    decoder_i  = 5'b11010;
    alu_rslt_i = 32'h102;
    dmem.ready = 1'b1;
    dmem.rdata = 32'h1234_5678;
`ifdef MEM_ALIGN_CHECK_EN
    #1;
    checks++;
    if (stall_o !== 1'b0 || dmem.req !== 1'b0) begin
      errs++;
      $display("FAIL mis_idle: got stall=%b req=%b want 0/0",
               stall_o, dmem.req);
    end
    tick();
    idle_inputs();
    checks++;
    if ({bus_err_o, dmem.req, wb_valid_o} !== 3'b100) begin
      errs++;
      $display("FAIL mis_err: got %b want 100",
               {bus_err_o, dmem.req, wb_valid_o});
    end
`else
    tick();
    checks++;
    if (dmem.req !== 1'b1 || dmem.addr !== 32'h102) begin
      errs++;
      $display("FAIL mis_pass: got %b/%h want 1/102",
               dmem.req, dmem.addr);
    end
    tick();
    idle_inputs();
    checks++;
    if ({bus_err_o, wb_valid_o} !== 2'b01
        || wb_rdata_o !== 32'h1234_5678) begin
      errs++;
      $display("FAIL mis_wb: got %b/%h want 01/12345678",
               {bus_err_o, wb_valid_o}, wb_rdata_o);
    end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_back_to_back();
    test_timeout();
    test_beq();
    test_reset_mid();
    test_align();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
